serial_full_subtractor: RTL and testbench
=========================================

# serial_full_subtractor

Parametrised bit-serial subtractor computing `diff = x - y - c_in` over `WIDTH` operands. It reuses the single-bit full-subtractor equations once per clock, with a registered borrow. Operands are captured on a `start` pulse, processed LSB-first, one bit per cycle. The result is presented with a one-cycle `done` pulse. It is the sequential, width-generic successor to the combinational full subtractor, for area-constrained datapaths.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range ≥ 1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `x`  in  WIDTH  minuend; sampled with `start`.
- `y`  in  WIDTH  subtrahend; sampled with `start`.
- `c_in`  in  1  borrow-in; sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  WIDTH  registered difference, `(x - y - c_in) mod 2^WIDTH`.
- `c_out`  out  1  final borrow-out; 1 iff `x < y + c_in` (unsigned).
- `zero`  out  1  high iff `diff == 0`; updated with `diff`.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE: when `start` = 1 at an edge:
  - Load `x` and `y` into shift registers `xs` and `ys`.
  - Load `c_in` into borrow register `b`.
  - Clear bit counter `cnt` to 0 and clear the work register.
  - Go to RUN.
- RUN, each edge, per-bit full subtractor:
  - `d = xs[0] ^ ys[0] ^ b`.
  - `b <= (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b)`.
  - Shift `d` into the work register from the MSB end.
  - Shift `xs` and `ys` right by 1.
  - `cnt <= cnt + 1`.
- RUN exit: at the edge where `cnt == WIDTH-1`:
  - Copy the completed work value to `diff`.
  - Set `c_out` to the new borrow.
  - Set `zero` to `(work value == 0)`.
  - Go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE on the next edge, unconditionally.
- `start` in RUN or DONE is ignored; there is no queuing.
- `diff`, `c_out` and `zero` change only on RUN→DONE. They hold their values through IDLE and through the next RUN.
- `cnt` is `$clog2(WIDTH+1)` bits wide. With WIDTH = 1, RUN lasts one cycle and the block equals a registered 1-bit full subtractor.
- Arithmetic is unsigned; no overflow flag. `c_out` is the only carry/borrow indication.

## Timing
- Reset (`rst_n` = 0, immediate, independent of `clk`):
  - State IDLE.
  - `busy` = 0, `done` = 0.
  - `diff` = 0, `c_out` = 0, `zero` = 0.
  - Internal registers cleared.
- Reset mid-operation aborts the operation. No `done` is produced, and outputs return to reset values.
- Latency, with `start` sampled at edge E0:
  - `busy` = 1 from E0 until edge E(WIDTH+1).
  - RUN occupies edges E1..E(WIDTH).
  - `diff`, `c_out` and `zero` are valid after E(WIDTH).
  - `done` = 1 between E(WIDTH) and E(WIDTH+1).
  - Back in IDLE after E(WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles. A new `start` is accepted at E(WIDTH+2) at the earliest.
- `x`, `y` and `c_in` may change freely after E0; they are not re-sampled.

## Test plan
- WIDTH=1, all 8 combinations of x/y/c_in:
  - `diff = x^y^c_in`.
  - `c_out = (~x&y)|(~(x^y)&c_in)`.
  - `done` one cycle, 2 edges after start.
- WIDTH=8, x=8'h35, y=8'h12, c_in=0 → diff=8'h23, c_out=0, zero=0, `done` high after E8.
- WIDTH=8, x=8'h00, y=8'h01, c_in=0 → diff=8'hFF, c_out=1. Then x=8'h80, y=8'h7F, c_in=1 → diff=8'h00, zero=1, c_out=0.
- WIDTH=8, x=8'hAA=y, c_in=1 → diff=8'hFF, c_out=1. Hold `start` high for 20 cycles → results match back-to-back operations spaced exactly 10 cycles apart, with no start accepted while `busy`.
- WIDTH=8, start x=8'h35, y=8'h12; assert `rst_n`=0 between E4 and E5 (asynchronously):
  - `busy`, `diff` and `done` go 0 immediately.
  - No `done` pulse afterwards.
  - A fresh start after release gives the correct 8'h23.
- WIDTH=16, random 200 operand triples checked against `(x - y - c_in)`, with `diff` = low 16 bits and `c_out` = borrow. Also check `diff` is stable between `done` pulses.

Source files
------------

// File: rtl/serial_full_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// master drives operands and start; slave returns status and result.
interface serial_full_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             c_out;
   logic             zero;

   modport master (
      output start, x, y, c_in,
      input  busy, done, diff, c_out, zero
   );

   modport slave (
      input  start, x, y, c_in,
      output busy, done, diff, c_out, zero
   );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = (x - y - c_in) mod 2^WIDTH, one bit per clock,
// LSB first, with a registered borrow. Result flags change only on RUN->DONE.
module serial_full_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_full_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] xs_q, xs_d;
   logic [WIDTH-1:0] ys_q, ys_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             b_q, b_d;
   logic             c_out_q, c_out_d;
   logic             zero_q, zero_d;

   // single-bit full subtractor on the current LSBs and borrow
   logic             bit_d;
   logic             bit_b;
   logic [WIDTH-1:0] work_shift;

   assign bit_d = xs_q[0] ^ ys_q[0] ^ b_q;
   assign bit_b = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & b_q);

   // new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
   generate
      if (WIDTH == 1) begin : g_w1
         assign work_shift = bit_d;
      end else begin : g_wn
         assign work_shift = {bit_d, work_q[WIDTH-1:1]};
      end
   endgenerate

   // next-state and datapath updates; everything holds unless the state says otherwise
   always_comb begin
      state_d = state_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      work_d  = work_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      b_d     = b_q;
      c_out_d = c_out_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               xs_d    = bus.x;
               ys_d    = bus.y;
               b_d     = bus.c_in;
               cnt_d   = '0;
               work_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            b_d    = bit_b;
            work_d = work_shift;
            xs_d   = xs_q >> 1;
            ys_d   = ys_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = work_shift;
               c_out_d = bit_b;
               zero_d  = (work_shift == '0);
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         xs_q    <= '0;
         ys_q    <= '0;
         work_q  <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         b_q     <= 1'b0;
         c_out_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         work_q  <= work_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         c_out_q <= c_out_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = (state_q == DONE);
   assign bus.diff  = diff_q;
   assign bus.c_out = c_out_q;
   assign bus.zero  = zero_q;
endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor at WIDTH = 1, 8 and 16.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_full_subtractor;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   serial_full_subtractor_if #(.WIDTH(1))  if1 ();
   serial_full_subtractor_if #(.WIDTH(8))  if8 ();
   serial_full_subtractor_if #(.WIDTH(16)) if16 ();

   serial_full_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
   serial_full_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_full_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one WIDTH=8 operation started at the next edge (E0), checked through E9
   task automatic run8(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                       input logic cv, input logic [7:0] ed, input logic ec, input logic ez);
      int ndone;
      if8.x = xv; if8.y = yv; if8.c_in = cv; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      if8.x = ~xv; if8.y = ~yv; if8.c_in = ~cv;
      chk({tag, ".busy_e0"}, 32'(if8.busy), 32'(1));
      ndone = 0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (if8.done) ndone++;
      end
      chk({tag, ".early_done"}, 32'(ndone), 32'(0));
      @(negedge clk);
      chk({tag, ".done_e8"}, 32'(if8.done), 32'(1));
      chk({tag, ".diff"}, 32'(if8.diff), 32'(ed));
      chk({tag, ".c_out"}, 32'(if8.c_out), 32'(ec));
      chk({tag, ".zero"}, 32'(if8.zero), 32'(ez));
      @(negedge clk);
      chk({tag, ".done_e9"}, 32'(if8.done), 32'(0));
      chk({tag, ".busy_e9"}, 32'(if8.busy), 32'(0));
   endtask

   initial begin
      int          ndone, t0, t1, busy9, lat, got, stable;
      logic        xv1, yv1, cv1;
      int          r;
      logic [15:0] xv, yv, prev16;
      logic        cv;
      logic [16:0] full;

      errors = 0; checks = 0;
      rst_n = 1'b0;
      if1.start = 0;  if1.x = '0;  if1.y = '0;  if1.c_in = 0;
      if8.start = 0;  if8.x = '0;  if8.y = '0;  if8.c_in = 0;
      if16.start = 0; if16.x = '0; if16.y = '0; if16.c_in = 0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst.busy8", 32'(if8.busy), 32'(0));
      chk("rst.done8", 32'(if8.done), 32'(0));
      chk("rst.diff8", 32'(if8.diff), 32'(0));
      chk("rst.cout8", 32'(if8.c_out), 32'(0));
      chk("rst.zero8", 32'(if8.zero), 32'(0));
      chk("rst.busy1", 32'(if1.busy), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // WIDTH=1: all eight combinations
      for (int i = 0; i < 8; i++) begin
         xv1 = i[2]; yv1 = i[1]; cv1 = i[0];
         r = int'(xv1) - int'(yv1) - int'(cv1);
         if1.x = xv1; if1.y = yv1; if1.c_in = cv1; if1.start = 1'b1;
         @(negedge clk);
         if1.start = 1'b0;
         chk("w1.busy_e0", 32'(if1.busy), 32'(1));
         chk("w1.done_e0", 32'(if1.done), 32'(0));
         @(negedge clk);
         chk("w1.done_e1", 32'(if1.done), 32'(1));
         chk("w1.diff", 32'(if1.diff), 32'(r & 1));
         chk("w1.c_out", 32'(if1.c_out), 32'(r < 0));
         @(negedge clk);
         chk("w1.done_e2", 32'(if1.done), 32'(0));
         chk("w1.busy_e2", 32'(if1.busy), 32'(0));
      end

      // WIDTH=8 directed vectors
      run8("w8.35m12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
      run8("w8.00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run8("w8.80m7F", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);
      run8("w8.AAmAA", 8'hAA, 8'hAA, 1'b1, 8'hFF, 1'b1, 1'b0);

      // start held for 20 cycles: accepted at E0 and E10 only
      if8.x = 8'hAA; if8.y = 8'hAA; if8.c_in = 1'b1; if8.start = 1'b1;
      ndone = 0; t0 = -1; t1 = -1; busy9 = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 19) if8.start = 1'b0;
         if (k == 9) busy9 = int'(if8.busy);
         if (if8.done) begin
            if (ndone == 0) t0 = k; else t1 = k;
            ndone++;
            chk("hold.diff", 32'(if8.diff), 32'(8'hFF));
            chk("hold.c_out", 32'(if8.c_out), 32'(1));
         end
      end
      chk("hold.ndone", 32'(ndone), 32'(2));
      chk("hold.t0", 32'(t0), 32'(8));
      chk("hold.t1", 32'(t1), 32'(18));
      chk("hold.busy_gap", 32'(busy9), 32'(0));

      // asynchronous reset between E4 and E5 aborts the operation
      if8.x = 8'h35; if8.y = 8'h12; if8.c_in = 1'b0; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort.busy_pre", 32'(if8.busy), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("abort.busy", 32'(if8.busy), 32'(0));
      chk("abort.done", 32'(if8.done), 32'(0));
      chk("abort.diff", 32'(if8.diff), 32'(0));
      chk("abort.c_out", 32'(if8.c_out), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (if8.done) ndone++;
      end
      chk("abort.no_done", 32'(ndone), 32'(0));
      run8("w8.after_abort", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

      // WIDTH=16: boundary then random operands; diff must hold between done pulses
      prev16 = '0;
      for (int i = 0; i < 200; i++) begin
         if (i == 0) begin
            xv = 16'h0000; yv = 16'hFFFF; cv = 1'b1;
         end else if (i == 1) begin
            xv = 16'hFFFF; yv = 16'h0000; cv = 1'b0;
         end else begin
            xv = 16'($urandom); yv = 16'($urandom); cv = 1'($urandom);
         end
         full = {1'b0, xv} - {1'b0, yv} - {16'd0, cv};
         if16.x = xv; if16.y = yv; if16.c_in = cv; if16.start = 1'b1;
         @(negedge clk);
         if16.start = 1'b0;
         if16.x = 16'($urandom); if16.y = 16'($urandom);
         got = 0; lat = 0; stable = 1;
         for (int k = 1; k <= 20 && got == 0; k++) begin
            @(negedge clk);
            if (if16.done) begin
               got = 1; lat = k;
            end else if (if16.diff !== prev16) begin
               stable = 0;
            end
         end
         chk("w16.latency", 32'(lat), 32'(16));
         chk("w16.diff", 32'(if16.diff), 32'(full[15:0]));
         chk("w16.c_out", 32'(if16.c_out), 32'(full[16]));
         chk("w16.zero", 32'(if16.zero), 32'(full[15:0] == 16'd0));
         chk("w16.stable", 32'(stable), 32'(1));
         prev16 = full[15:0];
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
